blit_write_coalesce: RTL and testbench
======================================

# blit_write_coalesce

Byte-to-word write coalescer feeding the blitter write FIFO. It accepts one 8-bit pixel write per cycle from pipeline stage p4. Writes that land in the same 32-bit word are merged into a one-word buffer. Each merged word is emitted as a single p5 write with byte strobes, so SDRAM write traffic drops by up to 4x for horizontal spans. It honours the FIFO's registered `write_fifo_full` and stalls p4 accordingly.

## Interface
- `IDLE_CYCLES`, 15: cycles without a p4 write before a partial word is flushed (only when the timeout feature is compiled in).
- `clock` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high.
- `p4_write` in 1: pixel write valid.
- `p4_address` in 26: byte address.
- `p4_wdata` in 8: pixel byte.
- `p4_flush` in 1: end of blit command; emit any held word.
- `p4_stall` out 1: upstream must not assert `p4_write` this cycle. Combinational, equal to `write_fifo_full`.
- `write_fifo_full` in 1: from the write FIFO; no p5 write may be issued while it is high.
- `p5_write` out 1: one-cycle write pulse.
- `p5_address` out 26: word address; bits [1:0] are always 0.
- `p5_wstrb` out 4: byte enables.
- `p5_wdata` out 32: merged data.
- `idle` out 1: buffer empty and no flush pending.
- `fault_detected` out 1: one-cycle pulse when `p4_write` arrives while `p4_stall` is high.

## Operation
- **State:**
  - `buf_valid`, `buf_addr[25:2]`, `buf_strb[3:0]`, `buf_data[31:0]`.
  - `flush_pend`.
  - `idle_cnt` (counter sized to `IDLE_CYCLES`, saturating).
- **Lane mapping:** little-endian.
  - lane = `p4_address[1:0]`.
  - Data goes to `buf_data[8*lane +: 8]`; strobe bit `lane` is set.
- **Hit:** `p4_write && buf_valid && buf_strb != 4'hF && p4_address[25:2] == buf_addr`.
- **Merge:** a hit merges into the buffer. Rewriting an already-set lane overwrites it (last write wins).
- **Miss:** `p4_write` while the buffer is valid and not a hit.
- **Emit condition:** `buf_valid && !write_fifo_full && (miss || buf_strb == 4'hF || flush_pend || p4_flush || timeout)`.
- **On emit:** `p5_*` is registered from the buffer. In the same cycle:
  - On a miss, the buffer is reloaded with the new byte (strobe = single lane).
  - Otherwise `buf_valid` clears.
- **Write while buffer is invalid:** loads the buffer; no emit.
- **Dropped writes:** a `p4_write` while `p4_stall` is high is dropped and pulses `fault_detected`. The buffer is untouched.
- **Flush:** `p4_flush` sets `flush_pend`, including when it coincides with `p4_write`.
  - `flush_pend` clears on any cycle where, after the update, the buffer is empty or is being emitted with nothing reloaded.
  - Flush plus miss in the same cycle: the old word is emitted now and the new byte the next non-full cycle.
- **Flush with an empty buffer:** no p5 write is produced.
- **Idle counter:** cleared by any `p4_write` or while the buffer is invalid. Otherwise it increments to saturation.
- **Timeout:** asserted when `idle_cnt == IDLE_CYCLES`.
- **Address wrap:** none; 26-bit compare only, no wrap handling needed.

## Timing
- **Reset values:** all outputs 0, except `idle` = 1 and `p4_stall` = `write_fifo_full`. The buffer is invalid, `flush_pend` = 0 and `idle_cnt` = 0.
- **Reset mid-operation:** held buffer contents are discarded, not emitted.
- **Latency:**
  - A completed word (4th lane written in cycle N) appears on `p5_write` in cycle N+2, provided the FIFO is not full.
  - The word written out by a miss in cycle N appears in cycle N+1.
- **Backpressure:** while `write_fifo_full` is high, no emits occur and the buffer holds. The emit happens on the first cycle it is low.
- **Throughput:** one p4 byte per cycle; at most one p5 write per cycle.

## Configuration
- `BLIT_WCOAL_TIMEOUT_EN` defined: the idle counter and timeout flush are present.
- Undefined: no counter and no timeout term. A partial word is emitted only on miss, full strobe or flush; `IDLE_CYCLES` is ignored.

## Structure
- Shared `blit_pkg`:
  - `blit_addr_t` (26-bit), `blit_waddr_t` (24-bit word address).
  - `blit_strb_t`, constant `BLIT_STRB_FULL = 4'hF`.
- No sub-module; lane merge and emit logic are one always_comb/always_ff pair.

## Test plan
- Bytes 0x11, 0x22, 0x33, 0x44 to 0x100–0x103 on consecutive cycles -> one p5 write: addr 0x100, strb F, data 0x44332211.
- Bytes to 0x100 then 0x205 -> write at 0x100 strb 1 data 0x00000011. Then `p4_flush` -> write at 0x204 strb 2 data 0x00002200, and `idle` returns to 1.
- Bytes 0xAA then 0xBB both to 0x101 -> single write at 0x100, strb 2, data 0x0000BB00.
- Partial word held with `write_fifo_full` = 1 for 20 cycles -> no p5 write and `p4_stall` = 1. Inject `p4_write` -> `fault_detected` pulse, buffer unchanged. Deassert full -> write issued next cycle.
- With `BLIT_WCOAL_TIMEOUT_EN`, one byte to 0x300 then idle -> write exactly `IDLE_CYCLES` + 1 cycles after the byte. Without the macro -> no write until `p4_flush`.
- Reset asserted with a partial word held -> no p5 write, `idle` = 1, outputs zero.

Source files
------------

// File: rtl/blit_pkg.sv
// blit_pkg: shared blitter write-path types.
// Address, word-address, strobe and data types plus lane helpers.
package blit_pkg;

  typedef logic [25:0] blit_addr_t;
  typedef logic [23:0] blit_waddr_t;
  typedef logic [3:0]  blit_strb_t;
  typedef logic [31:0] blit_word_t;
  typedef logic [1:0]  blit_lane_t;

  localparam blit_strb_t BLIT_STRB_FULL = 4'hF;

  // One-hot byte enable for a little-endian lane.
  function automatic blit_strb_t lane_strb(
    input blit_lane_t lane
  );
    return blit_strb_t'(4'b0001 << lane);
  endfunction

  // Byte placed in its lane, other lanes zero.
  function automatic blit_word_t lane_data(
    input blit_lane_t lane,
    input logic [7:0] b
  );
    return blit_word_t'(b) << {lane, 3'b000};
  endfunction

  // Mask covering one lane.
  function automatic blit_word_t lane_mask(
    input blit_lane_t lane
  );
    return blit_word_t'(32'hFF) << {lane, 3'b000};
  endfunction

endpackage

// File: rtl/blit_write_coalesce.sv
// blit_write_coalesce: merges p4 byte writes into strobed p5 word writes.
// Define BLIT_WCOAL_TIMEOUT_EN to add the idle-timeout flush of partial words.
module blit_write_coalesce
  import blit_pkg::*;
#(
  parameter int IDLE_CYCLES = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p4_write,
  input  logic [25:0] p4_address,
  input  logic [7:0]  p4_wdata,
  input  logic        p4_flush,
  output logic        p4_stall,
  input  logic        write_fifo_full,
  output logic        p5_write,
  output logic [25:0] p5_address,
  output logic [3:0]  p5_wstrb,
  output logic [31:0] p5_wdata,
  output logic        idle,
  output logic        fault_detected
);

  logic        r_valid;
  blit_waddr_t r_addr;
  blit_strb_t  r_strb;
  blit_word_t  r_data;
  logic        r_flush;

  logic        r_p5_write;
  blit_addr_t  r_p5_addr;
  blit_strb_t  r_p5_strb;
  blit_word_t  r_p5_data;
  logic        r_fault;

  logic        w_acc;
  blit_lane_t  w_lane;
  blit_strb_t  w_lstrb;
  blit_word_t  w_ldata;
  logic        w_hit;
  logic        w_miss;
  blit_strb_t  w_mstrb;
  blit_word_t  w_mdata;
  logic        w_emit;
  logic        w_timeout;

  logic        w_valid_nx;
  blit_waddr_t w_addr_nx;
  blit_strb_t  w_strb_nx;
  blit_word_t  w_data_nx;
  logic        w_flush_nx;

`ifdef BLIT_WCOAL_TIMEOUT_EN
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYCLES);

  logic [CW-1:0] r_idle_cnt;
  logic [CW-1:0] w_idle_nx;

  // Saturating count of idle cycles, including the current one.
  always_comb begin
    w_idle_nx = r_idle_cnt;
    if (p4_write || !r_valid)
      w_idle_nx = '0;
    else if (r_idle_cnt != IDLE_MAX)
      w_idle_nx = r_idle_cnt + CW'(1);
  end

  // Idle counter register.
  always_ff @(posedge clock) begin
    if (reset)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= w_idle_nx;
  end

  assign w_timeout = (w_idle_nx == IDLE_MAX);
`else
  logic w_unused_idle;
  assign w_unused_idle = ^IDLE_CYCLES;
  assign w_timeout = 1'b0;
`endif

  // Hit/miss classification, lane merge, emit decision, next buffer.
  always_comb begin
    w_acc   = p4_write && !write_fifo_full;
    w_lane  = p4_address[1:0];
    w_lstrb = lane_strb(w_lane);
    w_ldata = lane_data(w_lane, p4_wdata);
    w_hit   = w_acc && r_valid
           && (r_strb != BLIT_STRB_FULL)
           && (p4_address[25:2] == r_addr);
    w_miss  = w_acc && r_valid && !w_hit;
    w_mstrb = r_strb;
    w_mdata = r_data;
    if (w_hit) begin
      w_mstrb = r_strb | w_lstrb;
      w_mdata = (r_data & ~lane_mask(w_lane))
              | w_ldata;
    end
    w_emit = r_valid && !write_fifo_full
          && (w_miss
           || (r_strb == BLIT_STRB_FULL)
           || r_flush || p4_flush
           || w_timeout);
    w_valid_nx = r_valid;
    w_addr_nx  = r_addr;
    w_strb_nx  = r_strb;
    w_data_nx  = r_data;
    if (w_emit && !w_miss) begin
      // A hit on an emitting cycle rides out in the merged word.
      w_valid_nx = 1'b0;
    end else if (w_miss || (w_acc && !r_valid)) begin
      w_valid_nx = 1'b1;
      w_addr_nx  = p4_address[25:2];
      w_strb_nx  = w_lstrb;
      w_data_nx  = w_ldata;
    end else if (w_hit) begin
      w_strb_nx  = w_mstrb;
      w_data_nx  = w_mdata;
    end
    w_flush_nx = (r_flush || p4_flush) && w_valid_nx;
  end

  // Buffer, flush-pending and registered p5/fault outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_strb     <= '0;
      r_data     <= '0;
      r_flush    <= 1'b0;
      r_p5_write <= 1'b0;
      r_p5_addr  <= '0;
      r_p5_strb  <= '0;
      r_p5_data  <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_valid    <= w_valid_nx;
      r_addr     <= w_addr_nx;
      r_strb     <= w_strb_nx;
      r_data     <= w_data_nx;
      r_flush    <= w_flush_nx;
      r_p5_write <= w_emit;
      if (w_emit) begin
        r_p5_addr <= {r_addr, 2'b00};
        r_p5_strb <= w_mstrb;
        r_p5_data <= w_mdata;
      end
      r_fault    <= p4_write && write_fifo_full;
    end
  end

  assign p4_stall       = write_fifo_full;
  assign p5_write       = r_p5_write;
  assign p5_address     = r_p5_addr;
  assign p5_wstrb       = r_p5_strb;
  assign p5_wdata       = r_p5_data;
  assign idle           = !r_valid && !r_flush;
  assign fault_detected = r_fault;

endmodule

// File: tb/tb_blit_write_coalesce.sv
// tb_blit_write_coalesce: directed and random stimulus against
// a byte-level reference model of the write coalescer.
module tb_blit_write_coalesce;

  localparam int IDLE = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        p4_write;
  logic [25:0] p4_address;
  logic [7:0]  p4_wdata;
  logic        p4_flush;
  logic        p4_stall;
  logic        write_fifo_full;
  logic        p5_write;
  logic [25:0] p5_address;
  logic [3:0]  p5_wstrb;
  logic [31:0] p5_wdata;
  logic        idle;
  logic        fault_detected;

  always #5 clock = ~clock;

  blit_write_coalesce #(
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .p4_write       (p4_write),
    .p4_address     (p4_address),
    .p4_wdata       (p4_wdata),
    .p4_flush       (p4_flush),
    .p4_stall       (p4_stall),
    .write_fifo_full(write_fifo_full),
    .p5_write       (p5_write),
    .p5_address     (p5_address),
    .p5_wstrb       (p5_wstrb),
    .p5_wdata       (p5_wdata),
    .idle           (idle),
    .fault_detected (fault_detected)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: held bytes of one word, pending flush, idle run.
  bit          m_hv;
  bit          m_fp;
  logic [23:0] m_word;
  logic [7:0]  m_b [4];
  bit          m_s [4];
  int          m_idle;

  // Last p5 write seen from the DUT and count of them.
  int          n_p5 = 0;
  logic [25:0] cap_a;
  logic [3:0]  cap_s;
  logic [31:0] cap_d;

  task automatic m_load(input logic [25:0] a, input logic [7:0] d);
    m_hv   = 1;
    m_word = a[25:2];
    for (int i = 0; i < 4; i++) begin
      m_s[i] = 0;
      m_b[i] = 8'h00;
    end
    m_s[a[1:0]] = 1;
    m_b[a[1:0]] = d;
  endtask

  // One clock cycle: drive, predict, check after the edge.
  task automatic cyc(
    input bit          rst,
    input bit          wr,
    input logic [25:0] a,
    input logic [7:0]  d,
    input bit          fl,
    input bit          full
  );
    bit          e_w;
    bit          e_f;
    logic [25:0] e_a;
    logic [3:0]  e_s;
    logic [31:0] e_d;
    bit          acc;
    bit          fullw;
    bit          same;
    bit          neww;
    bit          to;
    bit          go;
    reset           = rst;
    p4_write        = wr;
    p4_address      = a;
    p4_wdata        = d;
    p4_flush        = fl;
    write_fifo_full = full;
    #1;
    chk("p4_stall", p4_stall, full);
    e_w = 0;
    e_f = 0;
    e_a = '0;
    e_s = '0;
    e_d = '0;
    if (rst) begin
      m_hv   = 0;
      m_fp   = 0;
      m_idle = 0;
    end else begin
      acc   = wr && !full;
      fullw = m_s[0] && m_s[1] && m_s[2] && m_s[3];
      same  = m_hv && acc && (a[25:2] == m_word) && !fullw;
      neww  = m_hv && acc && !same;
`ifdef BLIT_WCOAL_TIMEOUT_EN
      if (wr || !m_hv) m_idle = 0;
      else if (m_idle < IDLE) m_idle++;
      to = (m_idle == IDLE);
`else
      to = 0;
`endif
      go = m_hv && !full && (neww || fullw || m_fp || fl || to);
      if (same) begin
        m_s[a[1:0]] = 1;
        m_b[a[1:0]] = d;
      end
      if (go) begin
        e_w = 1;
        e_a = {m_word, 2'b00};
        for (int i = 0; i < 4; i++) begin
          e_s[i] = m_s[i];
          e_d[8*i +: 8] = m_s[i] ? m_b[i] : 8'h00;
        end
        if (neww) m_load(a, d);
        else m_hv = 0;
      end else if (acc && !m_hv) begin
        m_load(a, d);
      end
      m_fp = (m_fp || fl) && m_hv;
      e_f  = wr && full;
    end
    @(posedge clock);
    #1;
    chk("p5_write", p5_write, e_w);
    chk("fault", fault_detected, e_f);
    chk("idle", idle, !m_hv && !m_fp);
    if (rst) begin
      chk("rst_addr", p5_address, 0);
      chk("rst_strb", p5_wstrb, 0);
      chk("rst_data", p5_wdata, 0);
    end else if (e_w) begin
      chk("p5_addr", p5_address, e_a);
      chk("p5_strb", p5_wstrb, e_s);
      chk("p5_data", p5_wdata, e_d);
    end
    if (p5_write === 1'b1) begin
      n_p5++;
      cap_a = p5_address;
      cap_s = p5_wstrb;
      cap_d = p5_wdata;
    end
  endtask

  task automatic nop(input bit full);
    cyc(0, 0, '0, '0, 0, full);
  endtask

  int          base;
  int          k;
  bit          seen;
  logic [23:0] wsel;
  logic [25:0] ra;
  int          r;

  initial begin
    // Reset state
    cyc(1, 0, '0, '0, 0, 0);
    cyc(1, 0, '0, '0, 0, 0);
    nop(0);

    // Full horizontal span of four bytes
    base = n_p5;
    cyc(0, 1, 26'h100, 8'h11, 0, 0);
    cyc(0, 1, 26'h101, 8'h22, 0, 0);
    cyc(0, 1, 26'h102, 8'h33, 0, 0);
    cyc(0, 1, 26'h103, 8'h44, 0, 0);
    chk("span_early", n_p5 - base, 0);
    nop(0);
    chk("span_cnt", n_p5 - base, 1);
    chk("span_addr", cap_a, 26'h100);
    chk("span_strb", cap_s, 4'hF);
    chk("span_data", cap_d, 32'h44332211);

    // Miss emits the old word, flush emits the new one
    base = n_p5;
    cyc(0, 1, 26'h100, 8'h11, 0, 0);
    cyc(0, 1, 26'h205, 8'h22, 0, 0);
    chk("miss_cnt", n_p5 - base, 1);
    chk("miss_addr", cap_a, 26'h100);
    chk("miss_strb", cap_s, 4'h1);
    chk("miss_data", cap_d, 32'h00000011);
    cyc(0, 0, '0, '0, 1, 0);
    chk("fl_cnt", n_p5 - base, 2);
    chk("fl_addr", cap_a, 26'h204);
    chk("fl_strb", cap_s, 4'h2);
    chk("fl_data", cap_d, 32'h00002200);
    chk("fl_idle", idle, 1);

    // Same lane twice: last write wins
    base = n_p5;
    cyc(0, 1, 26'h101, 8'hAA, 0, 0);
    cyc(0, 1, 26'h101, 8'hBB, 0, 0);
    cyc(0, 0, '0, '0, 1, 0);
    chk("ow_cnt", n_p5 - base, 1);
    chk("ow_addr", cap_a, 26'h100);
    chk("ow_strb", cap_s, 4'h2);
    chk("ow_data", cap_d, 32'h0000BB00);

    // Backpressure with flush pending, plus a dropped write
    base = n_p5;
    cyc(0, 1, 26'h010, 8'h42, 0, 0);
    cyc(0, 0, '0, '0, 1, 1);
    for (int i = 0; i < 19; i++) nop(1);
    chk("bp_none", n_p5 - base, 0);
    cyc(0, 1, 26'h011, 8'h99, 0, 1);
    chk("bp_fault", fault_detected, 1);
    nop(0);
    chk("bp_cnt", n_p5 - base, 1);
    chk("bp_addr", cap_a, 26'h010);
    chk("bp_strb", cap_s, 4'h1);
    chk("bp_data", cap_d, 32'h00000042);

    // Idle timeout (or lack of it)
    base = n_p5;
    cyc(0, 1, 26'h300, 8'h5A, 0, 0);
    k    = 0;
    seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      nop(0);
      if (n_p5 != base) begin
        seen = 1;
        k    = i;
      end
    end
`ifdef BLIT_WCOAL_TIMEOUT_EN
    chk("to_seen", seen, 1);
    chk("to_lat", k, IDLE);
`else
    chk("to_none", seen, 0);
    cyc(0, 0, '0, '0, 1, 0);
    chk("to_flush", n_p5 - base, 1);
`endif
    chk("to_addr", cap_a, 26'h300);
    chk("to_data", cap_d, 32'h0000005A);

    // Reset discards a held word
    base = n_p5;
    cyc(0, 1, 26'h402, 8'h77, 0, 0);
    cyc(1, 0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) nop(0);
    chk("rst_none", n_p5 - base, 0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: wsel = 24'h000040;
        1: wsel = 24'h000041;
        2: wsel = 24'h000080;
        default: wsel = 24'($urandom);
      endcase
      ra = {wsel, 2'($urandom)};
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 7,
          ra,
          8'($urandom),
          $urandom_range(0, 19) == 0,
          $urandom_range(0, 4) == 0);
    end
    cyc(0, 0, '0, '0, 1, 0);
    for (int i = 0; i < 3; i++) nop(0);
    chk("end_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
